// File: rtl/count_ctrl_pkg.sv
// Shared types and widths for the button-driven run/pause/clear count controller.
package count_ctrl_pkg;
  localparam int COUNT_W = 8;

  typedef enum logic [1:0] {
    CC_IDLE  = 2'd0,
    CC_RUN   = 2'd1,
    CC_PAUSE = 2'd2
  } cc_state_t;
endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stable-level debouncer -> one-cycle press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          meta_q, s_q, deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q;

  // Any sample agreeing with the accepted level restarts qualification.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= 1'b0;
      s_q        <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      meta_q     <= btn_i;
      s_q        <= meta_q;
      deb_prev_q <= deb_q;
      if (s_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        deb_q <= s_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign press_o = deb_q & ~deb_prev_q;
endmodule

// File: rtl/count_ctrl.sv
// Run/pause/clear FSM gating a prescaled up/down counter for the display chain.
// Build option: COUNT_CTRL_SATURATE_EN makes the count hold at its limits instead of wrapping.
import count_ctrl_pkg::*;

module count_ctrl #(
  parameter int TICK_DIV   = 10,
  parameter int DEB_CYCLES = 4,
  parameter int MAX_COUNT  = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_clear,
  input  logic               btn_dir,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               dir_down
);
  localparam int PW = $clog2(TICK_DIV);

  logic [2:0] btn_raw, press;
  logic       start_p, clr_p, dir_p;

  assign btn_raw = {btn_dir, btn_clear, btn_start};

  for (genvar g = 0; g < 3; g++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (btn_raw[g]),
      .press_o(press[g])
    );
  end

  assign start_p = press[0];
  assign clr_p   = press[1];
  assign dir_p   = press[2];

  cc_state_t          state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d, running_q, tick;

  function automatic logic [COUNT_W-1:0] step(input logic [COUNT_W-1:0] c, input logic down);
    logic [COUNT_W-1:0] r;
    r = c;
`ifdef COUNT_CTRL_SATURATE_EN
    if (down) r = (c == '0) ? c : c - 1'b1;
    else      r = (c == COUNT_W'(MAX_COUNT)) ? c : c + 1'b1;
`else
    if (down) r = (c == '0) ? COUNT_W'(MAX_COUNT) : c - 1'b1;
    else      r = (c == COUNT_W'(MAX_COUNT)) ? '0 : c + 1'b1;
`endif
    return r;
  endfunction

  // Step uses the pre-toggle direction; clear overrides a same-cycle start or tick.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    dir_d   = dir_q;
    tick    = (state_q == CC_RUN) && (presc_q == PW'(TICK_DIV - 1));
    if (dir_p) dir_d = ~dir_q;
    if (state_q == CC_RUN) presc_d = tick ? '0 : presc_q + 1'b1;
    if (tick) count_d = step(count_q, dir_q);
    if (clr_p) begin
      state_d = CC_IDLE;
      count_d = '0;
      presc_d = '0;
    end else if (start_p) begin
      case (state_q)
        CC_IDLE: begin
          state_d = CC_RUN;
          presc_d = '0;
        end
        CC_RUN:   state_d = CC_PAUSE;
        CC_PAUSE: state_d = CC_RUN;
        default:  state_d = CC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CC_IDLE;
      presc_q   <= '0;
      count_q   <= '0;
      dir_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      running_q <= (state_d == CC_RUN);
    end
  end

  assign count    = count_q;
  assign running  = running_q;
  assign dir_down = dir_q;
endmodule

// File: tb/tb_count_ctrl.sv
// Self-checking bench for count_ctrl: expected count steps are queued as stimulus is applied
// and popped by a monitor whenever the DUT count changes; timing points are checked directly.
module tb_count_ctrl;
  logic       clk = 1'b0;
  logic       rst, btn_start, btn_clear, btn_dir;
  logic [7:0] count;
  logic       running, dir_down;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_cnt = '0;
  bit         mon_en = 1'b0;

  count_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_clear(btn_clear),
    .btn_dir  (btn_dir),
    .count    (count),
    .running  (running),
    .dir_down (dir_down)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Advance n active edges and sample just after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sb(input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      edges(1);
      k++;
    end
    if (exp_q.size() != 0) chk("sb_timeout", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && count !== prev_cnt) begin
      if (exp_q.size() == 0) chk("sb_extra", count, prev_cnt);
      else                   chk("sb_step", count, exp_q.pop_front());
    end
    prev_cnt = count;
  end

  initial begin
    rst = 1'b0; btn_start = 1'b0; btn_clear = 1'b0; btn_dir = 1'b0;
    edges(3);
    chk("rst_count", count, 0);
    chk("rst_running", running, 0);
    chk("rst_dir", dir_down, 0);
    rst = 1'b1;
    edges(3);

    // Bounce shorter than the qualification window is ignored.
    btn_start = 1'b1; edges(1); btn_start = 1'b0; edges(1);
    btn_start = 1'b1; edges(1); btn_start = 1'b0;
    edges(20);
    chk("glitch_running", running, 0);

    // Start: running at edge 7, steps every 10 edges.
    mon_en = 1'b1;
    btn_start = 1'b1;
    edges(6); chk("start_lat_pre", running, 0);
    edges(1); chk("start_lat", running, 1);
    btn_start = 1'b0;
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    edges(9); chk("step1_pre", count, 0);
    edges(1); chk("step1", count, 1);
    edges(9); chk("step2_pre", count, 1);
    edges(1); chk("step2", count, 2);

    // Pause 7 edges into the step period, resume: 3 edges remain.
    btn_start = 1'b1;
    edges(6); chk("pause_pre", running, 1);
    edges(1); chk("pause", running, 0);
    btn_start = 1'b0;
    edges(50);
    chk("pause_hold", count, 2);
    chk("pause_running", running, 0);
    btn_start = 1'b1;
    edges(7); chk("resume", running, 1);
    btn_start = 1'b0;
    exp_q.push_back(8'd3);
    edges(2); chk("resume_phase_pre", count, 2);
    edges(1); chk("resume_phase", count, 3);

    // Reverse at 3: 2, 1, 0 then wrap or hold.
    btn_dir = 1'b1;
    exp_q.push_back(8'd2); exp_q.push_back(8'd1); exp_q.push_back(8'd0);
`ifndef COUNT_CTRL_SATURATE_EN
    exp_q.push_back(8'd255);
`endif
    edges(7); chk("dir_toggle", dir_down, 1);
    btn_dir = 1'b0;
    wait_sb(60);
`ifdef COUNT_CTRL_SATURATE_EN
    edges(25);
    chk("sat_low", count, 0);
    chk("sat_low_running", running, 1);
`endif

    // Count up through MAX_COUNT.
    btn_dir = 1'b1;
`ifdef COUNT_CTRL_SATURATE_EN
    for (int v = 1; v <= 255; v++) exp_q.push_back(8'(v));
`else
    for (int v = 0; v <= 256; v++) exp_q.push_back(8'(v % 256));
`endif
    edges(7); chk("dir_up", dir_down, 0);
    btn_dir = 1'b0;
    wait_sb(2800);
`ifdef COUNT_CTRL_SATURATE_EN
    edges(30);
    chk("sat_high", count, 255);
    chk("sat_high_running", running, 1);
`else
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    wait_sb(40);
`endif

    // Clear and start together while running: clear wins.
    exp_q.push_back(8'd0);
    btn_clear = 1'b1; btn_start = 1'b1;
    edges(6); chk("clr_pre", running, 1);
    edges(1); chk("clr_running", running, 0);
    chk("clr_count", count, 0);
    btn_clear = 1'b0; btn_start = 1'b0;
    edges(30);
    chk("clr_start_discard", running, 0);
    chk("clr_hold", count, 0);

    // Direction toggles in IDLE without touching count.
    btn_dir = 1'b1;
    edges(7); chk("idle_dir", dir_down, 1);
    chk("idle_dir_count", count, 0);
    btn_dir = 1'b0;
    edges(10);
    btn_start = 1'b1;
    edges(7); chk("run2", running, 1);
    btn_start = 1'b0;
`ifndef COUNT_CTRL_SATURATE_EN
    exp_q.push_back(8'd255);
`endif
    edges(12);
`ifdef COUNT_CTRL_SATURATE_EN
    chk("sat_down_at0", count, 0);
`else
    chk("down_wrap", count, 255);
`endif

    // Asynchronous reset mid-run clears outputs before the next edge.
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("async_rst_count", count, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_dir", dir_down, 0);
    chk("sb_drain", exp_q.size(), 0);
    edges(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/count_ctrl.md
# count_ctrl

Button-driven run/pause/clear controller that produces the 8-bit binary count consumed by the BCD → seven-segment → digit-multiplexer display chain. It replaces the free-running counter stage: three push buttons are synchronised, debounced and edge-detected, and a small state machine gates a prescaled up/down counter. The `count` output connects directly to the display chain's 8-bit binary input.

## Interface
- `TICK_DIV`, default 10: clk cycles per count step while running; must be ≥ 2.
- `DEB_CYCLES`, default 4: consecutive stable synchronised samples required to accept a button level; must be ≥ 1.
- `MAX_COUNT`, default 255: upper count limit; must be ≤ 255.
- `clk`, input, 1: clock.
- `rst`, input, 1: asynchronous, active-low reset.
- `btn_start`, input, 1: raw, asynchronous, active-high; toggles run/pause.
- `btn_clear`, input, 1: raw, asynchronous, active-high; returns the block to idle with count 0.
- `btn_dir`, input, 1: raw, asynchronous, active-high; toggles count direction.
- `count`, output, 8: registered binary count, range 0..MAX_COUNT.
- `running`, output, 1: high while state is RUN.
- `dir_down`, output, 1: 0 = count up, 1 = count down.

## Operation
- Reset (rst low): `count`=0, `running`=0, `dir_down`=0, state=IDLE, prescaler=0, all synchroniser/debounce flops=0, no pulses pending.
- Per button:
  - 2-flop synchroniser produces `s`.
  - Debouncer holds level `deb`. While `s`≠`deb`, a counter increments each cycle. When the counter reaches DEB_CYCLES−1, `deb`←`s` and the counter clears.
  - Any cycle with `s`==`deb` clears the counter, so bounce restarts qualification.
  - `press` = `deb` & ~`deb_q` (registered previous level): a one-cycle pulse on each accepted press. Releases generate nothing.
- State machine (IDLE, RUN, PAUSE), driven by press pulses:
  - clear: any state → IDLE; `count`←0, prescaler←0.
  - start: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
  - clear and start in the same cycle: clear wins; the start is discarded.
- dir press toggles `dir_down` in any state, including IDLE. It has no effect on `count` or prescaler.
- Prescaler:
  - Runs only in RUN, counting 0..TICK_DIV−1 and wrapping to 0.
  - A tick occurs in the cycle where prescaler==TICK_DIV−1 and state==RUN.
  - Holds its value in PAUSE, so the step phase is preserved across pause/resume.
  - Entering RUN from IDLE starts it at 0.
- Tick arithmetic:
  - Up: `count`+1. Down: `count`−1.
  - Boundaries (see Configuration): up at MAX_COUNT, down at 0.
- A tick and a dir press in the same cycle: the step uses the old `dir_down`; the new direction applies from the next tick.
- A tick and a start press (RUN→PAUSE) in the same cycle: the step is applied, then the block pauses.

## Timing
- Button latency: a raw edge held stable reaches `deb` at clk edge 2+DEB_CYCLES. The press pulse is high for the following cycle. The state/`running` update lands at edge 3+DEB_CYCLES (7 with defaults).
- First step: `count` changes TICK_DIV clk edges after the edge that raises `running`.
- Steady state: one step every TICK_DIV cycles (default 10).
- All outputs are registered; there is no combinational input→output path.
- Reset assertion takes effect immediately, mid-debounce or mid-prescale. Release is synchronous to clk at the sync-flop level.

## Configuration
- `COUNT_CTRL_SATURATE_EN`:
  - Defined: `count` holds at MAX_COUNT when counting up and holds at 0 when counting down. The state remains RUN.
  - Undefined (default): up at MAX_COUNT wraps to 0; down at 0 wraps to MAX_COUNT.

## Structure
- Package `count_ctrl_pkg` contains:
  - state enum typedef `cc_state_t` {CC_IDLE, CC_RUN, CC_PAUSE};
  - localparam `COUNT_W`=8.
- Sub-module `btn_debounce` (synchroniser + debouncer + press pulse, parameter DEB_CYCLES), instantiated three times.
- Top-level `count_ctrl` holds the FSM, prescaler and counter.

## Test plan
- Reset, then btn_start held high with defaults → `running`=1 at edge 7; `count`: 0→1 10 cycles later, 1→2 after 10 more.
- btn_start toggling every cycle for 3 cycles, then low → no press accepted; `running` remains 0.
- Run to count=5, press start (pause) for 50 cycles, press start again → `count` holds 5 while paused; the next step resumes with the preserved prescaler phase.
- Count up at 255 (MAX_COUNT=255) → without the macro reaches 0; with `COUNT_CTRL_SATURATE_EN` holds 255.
- dir press at count=3 while running → subsequent steps 2, 1, 0, then 255 (wrap build).
- btn_clear and btn_start pressed simultaneously while in RUN at count=40 → state IDLE, `count`=0, `running`=0; asserting rst mid-run zeroes all outputs immediately.
